// File: rtl/color_pwm_driver_pkg.sv
// Shared colour codes, fade FSM encoding and the colour-to-duty mapping used by
// the colour PWM driver.
package color_pkg;

  localparam logic [1:0] COLOR_OFF  = 2'h0;
  localparam logic [1:0] COLOR_BLUE = 2'h1;
  localparam logic [1:0] COLOR_RED  = 2'h2;
  localparam logic [1:0] COLOR_HOLD = 2'h3;

  typedef enum logic {
    FADE_IDLE,
    FADE_ACTIVE
  } fade_state_t;

  typedef enum logic {
    CH_RED,
    CH_BLUE
  } channel_t;

  // Returned at 16 bits; callers narrow to their own PWM width.
  function automatic logic [15:0] target_duty(input logic [1:0]  code,
                                              input channel_t    ch,
                                              input logic [15:0] period);
    logic [15:0] duty;
    duty = '0;
    case (code)
      COLOR_BLUE: if (ch == CH_BLUE) duty = period;
      COLOR_RED:  if (ch == CH_RED)  duty = period;
      default:    duty = '0;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/color_pwm_driver_if.sv
// Colour/enable request from the colour FSM and the LED PWM outputs back to the
// board.
interface color_pwm_driver_if;
  logic [1:0] color_in;
  logic       en;
  logic       red_pwm;
  logic       blue_pwm;
  logic       busy;

  modport master (
    output color_in,
    output en,
    input  red_pwm,
    input  blue_pwm,
    input  busy
  );

  modport slave (
    input  color_in,
    input  en,
    output red_pwm,
    output blue_pwm,
    output busy
  );
endinterface

// File: rtl/color_pwm_channel.sv
// One LED channel: duty register stepping toward its target once per PWM
// period, plus the registered PWM compare.
module color_pwm_channel #(
  parameter int PWM_WIDTH = 8,
  parameter int FADE_STEP = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic                 step,
  input  logic                 en,
  input  logic [PWM_WIDTH-1:0] target,
  output logic                 pwm,
  output logic                 at_target
);

  localparam logic signed [PWM_WIDTH:0] STEP_S = (PWM_WIDTH+1)'(FADE_STEP);
  localparam logic [PWM_WIDTH-1:0]      STEP_D = PWM_WIDTH'(FADE_STEP);

  logic [PWM_WIDTH-1:0] duty;

  // Distance is signed in one extra bit, so a step never overshoots or wraps.
  function automatic logic [PWM_WIDTH-1:0] step_toward(input logic [PWM_WIDTH-1:0] cur,
                                                       input logic [PWM_WIDTH-1:0] tgt);
    logic signed [PWM_WIDTH:0] diff;
    logic [PWM_WIDTH-1:0]      nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)
      nxt = cur + STEP_D;
    else if (diff < -STEP_S)
      nxt = cur - STEP_D;
    else
      nxt = tgt;
    return nxt;
  endfunction

  assign at_target = (duty == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (step)
        duty <= step_toward(duty, target);
      pwm <= en & (cnt < duty);
    end
  end

endmodule

// File: rtl/color_pwm_driver.sv
// Turns the colour FSM code into red/blue LED PWM, crossfading one duty step
// per PWM period between colours.
module color_pwm_driver
  import color_pkg::*;
#(
  parameter int PWM_WIDTH = 8,
  parameter int FADE_STEP = 32
) (
  input  logic              clk,
  input  logic              rst,
  color_pwm_driver_if.slave bus
);

  typedef logic [PWM_WIDTH-1:0] duty_t;

  localparam int          PERIOD   = (1 << PWM_WIDTH) - 1;
  localparam logic [15:0] PERIOD16 = 16'(PERIOD);
  localparam duty_t       LAST     = duty_t'(PERIOD - 1);

  duty_t       cnt;
  logic [1:0]  target;
  fade_state_t state;
  logic        busy;
  logic        boundary;
  logic        step;
  duty_t       red_target;
  duty_t       blue_target;
  logic        red_at;
  logic        blue_at;
  logic        red_pwm;
  logic        blue_pwm;

  assign red_target  = duty_t'(target_duty(target, CH_RED,  PERIOD16));
  assign blue_target = duty_t'(target_duty(target, CH_BLUE, PERIOD16));

  // Steps use the target held before this edge; a same-edge colour change
  // takes effect at the following boundary.
  assign boundary = (cnt == LAST);
  assign step     = bus.en & boundary & (state == FADE_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      target <= COLOR_OFF;
      state  <= FADE_IDLE;
      busy   <= 1'b0;
    end else begin
      if (!bus.en || boundary)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (bus.color_in != COLOR_HOLD)
        target <= bus.color_in;

      case (state)
        FADE_IDLE: begin
          if (!(red_at && blue_at)) begin
            state <= FADE_ACTIVE;
            busy  <= 1'b1;
          end
        end
        FADE_ACTIVE: begin
          if (red_at && blue_at) begin
            state <= FADE_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= FADE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  color_pwm_channel #(
    .PWM_WIDTH (PWM_WIDTH),
    .FADE_STEP (FADE_STEP)
  ) u_red (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .step      (step),
    .en        (bus.en),
    .target    (red_target),
    .pwm       (red_pwm),
    .at_target (red_at)
  );

  color_pwm_channel #(
    .PWM_WIDTH (PWM_WIDTH),
    .FADE_STEP (FADE_STEP)
  ) u_blue (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .step      (step),
    .en        (bus.en),
    .target    (blue_target),
    .pwm       (blue_pwm),
    .at_target (blue_at)
  );

  assign bus.red_pwm  = red_pwm;
  assign bus.blue_pwm = blue_pwm;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_color_pwm_driver.sv
// Directed bench for color_pwm_driver: fades, reversal, hold code, enable
// freeze and mid-fade reset with hand-computed duty values.
module tb_color_pwm_driver;
  import color_pkg::*;

  localparam int LAST = 254;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_pwm_driver_if bus ();

  color_pwm_driver #(
    .PWM_WIDTH (8),
    .FADE_STEP (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int mcnt    = 0;
  int red_hi  = 0;
  int blue_hi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; the bench keeps its own model of the PWM counter.
  task automatic tick();
    int nxt;
    nxt = (rst || !bus.en || mcnt == LAST) ? 0 : mcnt + 1;
    @(posedge clk);
    #1;
    mcnt = nxt;
    if (bus.red_pwm)  red_hi++;
    if (bus.blue_pwm) blue_hi++;
  endtask

  // Advance through the next boundary edge (pre-edge count == LAST).
  task automatic to_boundary();
    int n;
    n = 0;
    while (mcnt != LAST && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $error("FAIL boundary_timeout observed %0d expected %0d", mcnt, LAST);
    end
    tick();
  endtask

  task automatic chk_duty(input string tag, input int r, input int b);
    chk({tag, "_red"},  32'(dut.u_red.duty),  r);
    chk({tag, "_blue"}, 32'(dut.u_blue.duty), b);
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.color_in = COLOR_OFF;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_red_pwm",  32'(bus.red_pwm),  0);
    chk("reset_blue_pwm", 32'(bus.blue_pwm), 0);
    chk("reset_busy",     32'(bus.busy),     0);
    chk("reset_cnt",      32'(dut.cnt),      0);
    chk_duty("reset", 0, 0);

    // OFF -> BLUE
    bus.color_in = COLOR_BLUE;
    bus.en       = 1'b1;
    tick();
    chk("blue_busy_early", 32'(bus.busy), 0);
    tick();
    chk("blue_busy_rise", 32'(bus.busy), 1);
    chk("blue_cnt_model", 32'(dut.cnt), mcnt);
    to_boundary();
    chk_duty("blue_b1", 0, 32);
    for (int k = 2; k <= 8; k++) begin
      red_hi  = 0;
      blue_hi = 0;
      repeat (255) tick();
      chk("blue_pwm_count", 32'(blue_hi), 32 * (k - 1));
      chk("blue_red_quiet", 32'(red_hi), 0);
      chk_duty("blue_step", 0, (k == 8) ? 255 : 32 * k);
    end
    chk("blue_busy_last", 32'(bus.busy), 1);
    tick();
    chk("blue_busy_fall", 32'(bus.busy), 0);

    // BLUE -> RED crossfade
    bus.color_in = COLOR_RED;
    tick();
    tick();
    chk("red_busy_rise", 32'(bus.busy), 1);
    for (int k = 1; k <= 8; k++) begin
      to_boundary();
      chk_duty("xfade", (k == 8) ? 255 : 32 * k, (k == 8) ? 0 : 255 - 32 * k);
    end
    tick();
    chk("xfade_busy_fall", 32'(bus.busy), 0);
    red_hi  = 0;
    blue_hi = 0;
    repeat (255) tick();
    chk("red_settled_count",  32'(red_hi),  255);
    chk("red_settled_blue",   32'(blue_hi), 0);

    // RED -> OFF, then BLUE fade reversed at 96
    bus.color_in = COLOR_OFF;
    tick();
    tick();
    repeat (8) to_boundary();
    chk_duty("off", 0, 0);
    tick();
    chk("off_busy_fall", 32'(bus.busy), 0);
    bus.color_in = COLOR_BLUE;
    tick();
    tick();
    repeat (3) to_boundary();
    chk_duty("rev_peak", 0, 96);
    bus.color_in = COLOR_OFF;
    to_boundary();
    chk_duty("rev_64", 0, 64);
    to_boundary();
    chk_duty("rev_32", 0, 32);
    to_boundary();
    chk_duty("rev_0", 0, 0);
    chk("rev_busy_last", 32'(bus.busy), 1);
    tick();
    chk("rev_busy_fall", 32'(bus.busy), 0);

    // HOLD code during a RED fade
    bus.color_in = COLOR_RED;
    tick();
    tick();
    repeat (2) to_boundary();
    chk_duty("hold_start", 64, 0);
    bus.color_in = COLOR_HOLD;
    repeat (100) tick();
    chk("hold_target", 32'(dut.target), 32'(COLOR_RED));
    chk("hold_busy",   32'(bus.busy), 1);
    repeat (6) to_boundary();
    chk_duty("hold_done", 255, 0);
    tick();
    chk("hold_busy_fall", 32'(bus.busy), 0);

    // Enable freeze at blue=128
    bus.color_in = COLOR_BLUE;
    tick();
    tick();
    repeat (4) to_boundary();
    chk_duty("en_pre", 127, 128);
    bus.en = 1'b0;
    tick();
    chk("en_off_red_pwm",  32'(bus.red_pwm),  0);
    chk("en_off_blue_pwm", 32'(bus.blue_pwm), 0);
    red_hi  = 0;
    blue_hi = 0;
    repeat (1000) tick();
    chk("en_off_red_hi",  32'(red_hi),  0);
    chk("en_off_blue_hi", 32'(blue_hi), 0);
    chk_duty("en_frozen", 127, 128);
    chk("en_off_cnt",  32'(dut.cnt),  0);
    chk("en_off_busy", 32'(bus.busy), 1);
    bus.en = 1'b1;
    tick();
    chk("en_restart_cnt", 32'(dut.cnt), 1);
    to_boundary();
    chk_duty("en_resume", 95, 160);

    // Reset pulse mid-fade
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_red_pwm",  32'(bus.red_pwm),  0);
    chk("rst_blue_pwm", 32'(bus.blue_pwm), 0);
    chk("rst_busy",     32'(bus.busy),     0);
    chk("rst_cnt",      32'(dut.cnt),      0);
    chk("rst_target",   32'(dut.target),   32'(COLOR_OFF));
    chk_duty("rst", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
